// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes the instruction, tracks in-flight destinations in a
// busy scoreboard, stalls on hazards and selects operands with an optional writeback bypass.
module operand_fetch #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic [4:0]  read_reg_1,
  output logic [4:0]  read_reg_2,
  input  logic [31:0] read_data_1,
  input  logic [31:0] read_data_2,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [4:0]  out_rd,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic        out_wr_rd,
  output logic        out_illegal
);

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_kind_t;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic        use1, use2, wr_op, illegal, wr_rd;
  imm_kind_t   kind;
  logic [31:0] imm;
  logic [31:0] busy, busy_next;
  logic        fwd1, fwd2, haz1, haz2, hazard, accept, fire;
  logic [31:0] op1, op2;

  assign opcode     = in_instr[6:0];
  assign rd         = in_instr[11:7];
  assign rs1        = in_instr[19:15];
  assign rs2        = in_instr[24:20];
  assign read_reg_1 = rs1;
  assign read_reg_2 = rs2;

  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    wr_op   = 1'b0;
    illegal = 1'b0;
    kind    = IMM_NONE;
    case (opcode)
      7'b0110011: begin use1 = 1'b1; use2 = 1'b1; wr_op = 1'b1; end
      7'b0010011, 7'b0000011, 7'b1100111: begin use1 = 1'b1; wr_op = 1'b1; kind = IMM_I; end
      7'b0100011: begin use1 = 1'b1; use2 = 1'b1; kind = IMM_S; end
      7'b1100011: begin use1 = 1'b1; use2 = 1'b1; kind = IMM_B; end
      7'b0110111, 7'b0010111: begin wr_op = 1'b1; kind = IMM_U; end
      7'b1101111: begin wr_op = 1'b1; kind = IMM_J; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    imm = '0;
    case (kind)
      IMM_I:   imm = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:   imm = {in_instr[31:12], 12'b0};
      IMM_J:   imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign wr_rd = wr_op && (rd != '0);

  // A busy source is still usable when its value is being written back this cycle.
  assign fwd1 = FWD_EN && wb_en && (wb_rd == rs1);
  assign fwd2 = FWD_EN && wb_en && (wb_rd == rs2);
  assign haz1 = use1 && (rs1 != '0) &&
                ((busy[rs1] && !fwd1) || (out_valid && out_wr_rd && (out_rd == rs1)));
  assign haz2 = use2 && (rs2 != '0) &&
                ((busy[rs2] && !fwd2) || (out_valid && out_wr_rd && (out_rd == rs2)));
  assign hazard = haz1 || haz2;

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign fire     = out_valid && out_ready && !flush;

  assign op1 = (rs1 == '0) ? '0 : (fwd1 ? wb_data : read_data_1);
  assign op2 = (rs2 == '0) ? '0 : (fwd2 ? wb_data : read_data_2);

  // Clear first so a same-index issue overrides the writeback.
  always_comb begin
    busy_next = busy;
    if (wb_en && (wb_rd != '0)) busy_next[wb_rd] = 1'b0;
    if (fire && out_wr_rd)      busy_next[out_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_rd      <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_wr_rd   <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_opcode  <= opcode;
      out_funct3  <= in_instr[14:12];
      out_funct7  <= in_instr[31:25];
      out_rd      <= rd;
      out_rs1_val <= op1;
      out_rs2_val <= op2;
      out_imm     <= imm;
      out_wr_rd   <= wr_rd;
      out_illegal <= illegal;
    end else if (fire || flush) begin
      out_valid <= 1'b0;
    end
  end

endmodule
